// File: rtl/regfile_param_if.sv
// rtl/regfile_param_if.sv - decode-stage register file bus: two read ports, two write ports, alloc
// master = pipeline side driving addresses/writes, slave = register file.
interface regfile_param_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegisterB;
  logic [DATA_W-1:0] WriteDataB;
  logic              RegWriteB;
  logic [ADDR_W-1:0] AllocReg;
  logic              Alloc;
  logic              Pending1;
  logic              Pending2;

  modport master (
    output ReadRegister1, ReadRegister2,
    output WriteRegister, WriteData, RegWrite,
    output WriteRegisterB, WriteDataB, RegWriteB,
    output AllocReg, Alloc,
    input  ReadData1, ReadData2, Pending1, Pending2
  );

  modport slave (
    input  ReadRegister1, ReadRegister2,
    input  WriteRegister, WriteData, RegWrite,
    input  WriteRegisterB, WriteDataB, RegWriteB,
    input  AllocReg, Alloc,
    output ReadData1, ReadData2, Pending1, Pending2
  );
endinterface

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file with dual write, bypass and pending scoreboard
// Reads and pending lookups are combinational; all state updates on the rising edge.
module regfile_param #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic           clk,
  input  logic           reset,
  regfile_param_if.slave bus
);
  localparam int N = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = '1;

  logic [DATA_W-1:0] regs_q [N];
  logic [DATA_W-1:0] regs_d [N];
  logic [N-1:0]      pend_q;
  logic [N-1:0]      pend_d;

  logic wa_en, wb_en, al_en, fwd_ok;
  logic zero1, zero2;
  logic hit_a1, hit_b1, hit_a2, hit_b2;

  // Writes and allocs aimed at the hardwired zero register are dropped here,
  // so nothing downstream needs to special-case it.
  assign wa_en = bus.RegWrite  && !((ZERO_REG != 0) && (bus.WriteRegister  == ZADDR));
  assign wb_en = bus.RegWriteB && !((ZERO_REG != 0) && (bus.WriteRegisterB == ZADDR));
  assign al_en = bus.Alloc     && !((ZERO_REG != 0) && (bus.AllocReg       == ZADDR));
  assign fwd_ok = (BYPASS != 0) && !reset;

  always_comb begin
    regs_d = regs_q;
    // Port B first so port A overrides it on an address collision.
    if (wb_en) regs_d[bus.WriteRegisterB] = bus.WriteDataB;
    if (wa_en) regs_d[bus.WriteRegister]  = bus.WriteData;
  end

  always_comb begin
    pend_d = pend_q;
    if (wa_en) pend_d[bus.WriteRegister]  = 1'b0;
    if (wb_en) pend_d[bus.WriteRegisterB] = 1'b0;
    // Alloc is applied last: it belongs to a younger instruction than any retiring write.
    if (al_en) pend_d[bus.AllocReg] = 1'b1;
    if (ZERO_REG != 0) pend_d[ZADDR] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  assign zero1  = (ZERO_REG != 0) && (bus.ReadRegister1 == ZADDR);
  assign zero2  = (ZERO_REG != 0) && (bus.ReadRegister2 == ZADDR);
  assign hit_a1 = fwd_ok && wa_en && (bus.WriteRegister  == bus.ReadRegister1);
  assign hit_b1 = fwd_ok && wb_en && (bus.WriteRegisterB == bus.ReadRegister1);
  assign hit_a2 = fwd_ok && wa_en && (bus.WriteRegister  == bus.ReadRegister2);
  assign hit_b2 = fwd_ok && wb_en && (bus.WriteRegisterB == bus.ReadRegister2);

  assign bus.ReadData1 = zero1  ? '0 :
                         hit_a1 ? bus.WriteData :
                         hit_b1 ? bus.WriteDataB : regs_q[bus.ReadRegister1];
  assign bus.ReadData2 = zero2  ? '0 :
                         hit_a2 ? bus.WriteData :
                         hit_b2 ? bus.WriteDataB : regs_q[bus.ReadRegister2];

  // A forwarded result resolves the hazard in the same cycle.
  assign bus.Pending1 = !zero1 && pend_q[bus.ReadRegister1] && !(hit_a1 || hit_b1);
  assign bus.Pending2 = !zero2 && pend_q[bus.ReadRegister2] && !(hit_a2 || hit_b2);
endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - self-checking bench for regfile_param, bypass and non-bypass builds
module tb_regfile_param;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rr1, rr2, wa, wb, al;
  logic [63:0] wd, wdb;
  logic        we_a, we_b, alloc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] m_mem  [32];
  bit          m_pend [32];

  regfile_param_if #(.DATA_W(64), .ADDR_W(5)) bus1 ();
  regfile_param_if #(.DATA_W(64), .ADDR_W(5)) bus0 ();

  assign bus1.ReadRegister1 = rr1;   assign bus0.ReadRegister1 = rr1;
  assign bus1.ReadRegister2 = rr2;   assign bus0.ReadRegister2 = rr2;
  assign bus1.WriteRegister = wa;    assign bus0.WriteRegister = wa;
  assign bus1.WriteData = wd;        assign bus0.WriteData = wd;
  assign bus1.RegWrite = we_a;       assign bus0.RegWrite = we_a;
  assign bus1.WriteRegisterB = wb;   assign bus0.WriteRegisterB = wb;
  assign bus1.WriteDataB = wdb;      assign bus0.WriteDataB = wdb;
  assign bus1.RegWriteB = we_b;      assign bus0.RegWriteB = we_b;
  assign bus1.AllocReg = al;         assign bus0.AllocReg = al;
  assign bus1.Alloc = alloc;         assign bus0.Alloc = alloc;

  regfile_param #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_byp (
    .clk(clk), .reset(rst), .bus(bus1));
  regfile_param #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nobyp (
    .clk(clk), .reset(rst), .bus(bus0));

  always #5 clk = ~clk;

  function automatic logic [63:0] m_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd31) return 64'd0;
    if (byp && !rst && we_a && wa == a) return wd;
    if (byp && !rst && we_b && wb == a) return wdb;
    return m_mem[a];
  endfunction

  function automatic bit m_pd(input logic [4:0] a, input bit byp);
    if (a == 5'd31) return 1'b0;
    if (byp && !rst && ((we_a && wa == a) || (we_b && wb == a))) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_mem[i] = 64'd0; m_pend[i] = 1'b0; end
    end else begin
      if (we_b && wb != 5'd31) m_mem[wb] = wdb;
      if (we_a && wa != 5'd31) m_mem[wa] = wd;
      if (we_b) m_pend[wb] = 1'b0;
      if (we_a) m_pend[wa] = 1'b0;
      if (alloc && al != 5'd31) m_pend[al] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    we_a = 0; we_b = 0; alloc = 0; rst = 0;
    wa = 0; wb = 0; al = 0; wd = 0; wdb = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; rr1 = 0; rr2 = 0;
    step();
    rst = 0;
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i); rr2 = 5'(31 - i);
      #2;
      n_checks++;
      if (bus1.ReadData1 !== 64'd0 || bus0.ReadData2 !== 64'd0) begin
        n_fail++; $display("FAIL reset_data[%0d]: got %h/%h expected 0", i, bus1.ReadData1, bus0.ReadData2);
      end
      n_checks++;
      if (bus1.Pending1 !== 1'b0 || bus0.Pending2 !== 1'b0) begin
        n_fail++; $display("FAIL reset_pend[%0d]: got %b/%b expected 0", i, bus1.Pending1, bus0.Pending2);
      end
      step();
    end
  endtask

  task automatic test_sweep();
    logic [63:0] e;
    for (int i = 0; i < 32; i++) begin
      idle(); we_a = 1; wa = 5'(i);
      wd = (i == 31) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h1111_0000_0000_0000 + 64'(i);
      rr1 = 5'(i); rr2 = 5'($urandom_range(0, 31));
      e = (i == 31) ? 64'd0 : wd;
      #2;
      n_checks++;
      if (bus1.ReadData1 !== e) begin
        n_fail++; $display("FAIL sweep_bypass[%0d]: got %h expected %h", i, bus1.ReadData1, e);
      end
      n_checks++;
      if (bus0.ReadData1 !== m_rd(rr1, 0)) begin
        n_fail++; $display("FAIL sweep_nobyp[%0d]: got %h expected %h", i, bus0.ReadData1, m_rd(rr1, 0));
      end
      step();
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i); rr2 = 5'(31 - i);
      #2;
      e = (i == 31) ? 64'd0 : 64'h1111_0000_0000_0000 + 64'(i);
      n_checks++;
      if (bus1.ReadData1 !== e || bus0.ReadData1 !== e) begin
        n_fail++; $display("FAIL sweep_rd1[%0d]: got %h/%h expected %h", i, bus1.ReadData1, bus0.ReadData1, e);
      end
      e = (i == 0) ? 64'd0 : 64'h1111_0000_0000_0000 + 64'(31 - i);
      n_checks++;
      if (bus1.ReadData2 !== e || bus0.ReadData2 !== e) begin
        n_fail++; $display("FAIL sweep_rd2[%0d]: got %h/%h expected %h", i, bus1.ReadData2, bus0.ReadData2, e);
      end
      step();
    end
  endtask

  task automatic test_bypass();
    idle(); we_a = 1; wa = 5; wd = 64'hDEAD; rr1 = 5; rr2 = 0;
    #2;
    n_checks++;
    if (bus1.ReadData1 !== 64'hDEAD) begin
      n_fail++; $display("FAIL bypass_same: got %h expected %h", bus1.ReadData1, 64'hDEAD);
    end
    n_checks++;
    if (bus0.ReadData1 !== 64'h1111_0000_0000_0005) begin
      n_fail++; $display("FAIL nobypass_old: got %h expected %h", bus0.ReadData1, 64'h1111_0000_0000_0005);
    end
    step(); idle(); #2;
    n_checks++;
    if (bus1.ReadData1 !== 64'hDEAD || bus0.ReadData1 !== 64'hDEAD) begin
      n_fail++; $display("FAIL bypass_after: got %h/%h expected %h", bus1.ReadData1, bus0.ReadData1, 64'hDEAD);
    end
    step();
  endtask

  task automatic test_dual_write();
    idle(); we_a = 1; wa = 7; wd = 64'hA; we_b = 1; wb = 7; wdb = 64'hB; rr2 = 7;
    #2;
    n_checks++;
    if (bus1.ReadData2 !== 64'hA) begin
      n_fail++; $display("FAIL dual_same: got %h expected %h", bus1.ReadData2, 64'hA);
    end
    step(); idle(); #2;
    n_checks++;
    if (bus1.ReadData2 !== 64'hA || bus0.ReadData2 !== 64'hA) begin
      n_fail++; $display("FAIL dual_after: got %h/%h expected %h", bus1.ReadData2, bus0.ReadData2, 64'hA);
    end
    step();
  endtask

  task automatic test_scoreboard();
    idle(); alloc = 1; al = 3; rr1 = 3;
    #2;
    n_checks++;
    if (bus1.Pending1 !== 1'b0) begin
      n_fail++; $display("FAIL alloc_same_cycle: got %b expected 0", bus1.Pending1);
    end
    step(); idle();
    for (int k = 0; k < 2; k++) begin
      #2;
      n_checks++;
      if (bus1.Pending1 !== 1'b1 || bus0.Pending1 !== 1'b1) begin
        n_fail++; $display("FAIL alloc_hold[%0d]: got %b/%b expected 1", k, bus1.Pending1, bus0.Pending1);
      end
      step();
    end
    we_b = 1; wb = 3; wdb = 64'h33;
    #2;
    n_checks++;
    if (bus1.Pending1 !== 1'b0 || bus1.ReadData1 !== 64'h33) begin
      n_fail++; $display("FAIL wb_clear_byp: got %b/%h expected 0/%h", bus1.Pending1, bus1.ReadData1, 64'h33);
    end
    n_checks++;
    if (bus0.Pending1 !== 1'b1) begin
      n_fail++; $display("FAIL wb_clear_nobyp: got %b expected 1", bus0.Pending1);
    end
    step(); idle(); #2;
    n_checks++;
    if (bus0.Pending1 !== 1'b0 || bus0.ReadData1 !== 64'h33) begin
      n_fail++; $display("FAIL wb_after: got %b/%h expected 0/%h", bus0.Pending1, bus0.ReadData1, 64'h33);
    end
    alloc = 1; al = 3; we_a = 1; wa = 3; wd = 64'h44;
    step(); idle(); #2;
    n_checks++;
    if (bus1.Pending1 !== 1'b1 || bus0.Pending1 !== 1'b1 || bus1.ReadData1 !== 64'h44) begin
      n_fail++; $display("FAIL alloc_write_same: got %b/%b/%h expected 1/1/%h", bus1.Pending1, bus0.Pending1, bus1.ReadData1, 64'h44);
    end
    step();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 31; i++) begin
      idle(); we_a = 1; wa = 5'(i); wd = {$urandom, $urandom} | 64'd1;
      step();
    end
    idle(); alloc = 1; al = 2; step();
    idle(); alloc = 1; al = 9; step();
    idle(); rr1 = 2; rr2 = 9; #2;
    n_checks++;
    if (bus1.Pending1 !== 1'b1 || bus1.Pending2 !== 1'b1) begin
      n_fail++; $display("FAIL mid_pend_pre: got %b/%b expected 1/1", bus1.Pending1, bus1.Pending2);
    end
    rst = 1; we_a = 1; wa = 4; wd = 64'h1234_5678; rr1 = 4;
    #2;
    n_checks++;
    if (bus1.ReadData1 !== m_mem[4]) begin
      n_fail++; $display("FAIL mid_no_bypass_in_reset: got %h expected %h", bus1.ReadData1, m_mem[4]);
    end
    step(); idle();
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i); rr2 = 5'(i);
      #2;
      n_checks++;
      if (bus1.ReadData1 !== 64'd0 || bus0.ReadData2 !== 64'd0 || bus1.Pending1 !== 1'b0 || bus0.Pending2 !== 1'b0) begin
        n_fail++; $display("FAIL mid_cleared[%0d]: got %h/%h/%b/%b expected 0", i, bus1.ReadData1, bus0.ReadData2, bus1.Pending1, bus0.Pending2);
      end
      step();
    end
  endtask

  task automatic test_zero_alloc();
    idle(); alloc = 1; al = 31;
    step(); idle(); rr1 = 31; #2;
    n_checks++;
    if (bus1.Pending1 !== 1'b0 || bus1.ReadData1 !== 64'd0 || bus0.Pending1 !== 1'b0) begin
      n_fail++; $display("FAIL zero_alloc: got %b/%h/%b expected 0/0/0", bus1.Pending1, bus1.ReadData1, bus0.Pending1);
    end
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 59) == 0);
      we_a  = $urandom_range(0, 1);
      we_b  = $urandom_range(0, 1);
      alloc = $urandom_range(0, 1);
      // Narrow address range half the time so collisions actually happen.
      wa  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(28, 31));
      wb  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(28, 31));
      al  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(28, 31));
      rr1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(28, 31));
      rr2 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(28, 31));
      wd  = {$urandom, $urandom};
      wdb = {$urandom, $urandom};
      #2;
      n_checks++;
      if (bus1.ReadData1 !== m_rd(rr1, 1) || bus1.ReadData2 !== m_rd(rr2, 1)) begin
        n_fail++; $display("FAIL rand_byp_data[%0d]: got %h/%h expected %h/%h", c, bus1.ReadData1, bus1.ReadData2, m_rd(rr1, 1), m_rd(rr2, 1));
      end
      n_checks++;
      if (bus0.ReadData1 !== m_rd(rr1, 0) || bus0.ReadData2 !== m_rd(rr2, 0)) begin
        n_fail++; $display("FAIL rand_nobyp_data[%0d]: got %h/%h expected %h/%h", c, bus0.ReadData1, bus0.ReadData2, m_rd(rr1, 0), m_rd(rr2, 0));
      end
      n_checks++;
      if (bus1.Pending1 !== m_pd(rr1, 1) || bus1.Pending2 !== m_pd(rr2, 1) ||
          bus0.Pending1 !== m_pd(rr1, 0) || bus0.Pending2 !== m_pd(rr2, 0)) begin
        n_fail++; $display("FAIL rand_pending[%0d]: got %b%b/%b%b expected %b%b/%b%b", c,
          bus1.Pending1, bus1.Pending2, bus0.Pending1, bus0.Pending2,
          m_pd(rr1, 1), m_pd(rr2, 1), m_pd(rr1, 0), m_pd(rr2, 0));
      end
      step();
    end
    idle();
  endtask

  initial begin
    idle(); rst = 1; rr1 = 0; rr2 = 0;
    for (int i = 0; i < 32; i++) begin m_mem[i] = 64'd0; m_pend[i] = 1'b0; end
    @(negedge clk);
    test_reset();
    test_sweep();
    test_bypass();
    test_dual_write();
    test_scoreboard();
    test_reset_mid();
    test_zero_alloc();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor to the CPU's 32×64 register file: configurable width and depth, a second write port, same-cycle write-to-read bypass and a per-register pending scoreboard for pipeline hazard detection. It sits in the decode stage. Reads are asynchronous. Writes come from the writeback stage. Allocations come from issue, which marks a destination as awaiting a result.

## Interface
Parameters:
- DATA_W, 64, bits per register
- ADDR_W, 5, address width; depth N = 2^ADDR_W
- ZERO_REG, 1, 1 = register N-1 hardwired to zero; 0 = all N registers writable
- BYPASS, 1, 1 = forward same-cycle write data to read ports

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; clears all registers and all pending bits
- ReadRegister1  in  ADDR_W  read port 1 address
- ReadRegister2  in  ADDR_W  read port 2 address
- ReadData1  out  DATA_W  read port 1 data (combinational)
- ReadData2  out  DATA_W  read port 2 data (combinational)
- WriteRegister  in  ADDR_W  write port A address (ALU writeback)
- WriteData  in  DATA_W  write port A data
- RegWrite  in  1  write port A enable
- WriteRegisterB  in  ADDR_W  write port B address (load writeback)
- WriteDataB  in  DATA_W  write port B data
- RegWriteB  in  1  write port B enable
- AllocReg  in  ADDR_W  register to mark pending
- Alloc  in  1  allocate enable
- Pending1  out  1  pending bit of ReadRegister1 (combinational)
- Pending2  out  1  pending bit of ReadRegister2 (combinational)

## Operation
- State: N×DATA_W data array plus an N-bit pending vector.
- Reset:
  - All data bits and pending bits become 0 at the edge.
  - Reset overrides any write or alloc in the same cycle.
- Write:
  - On each edge with RegWrite=1, reg[WriteRegister] takes WriteData.
  - On each edge with RegWriteB=1, reg[WriteRegisterB] takes WriteDataB.
  - When both ports target the same address, port A wins and port B data is discarded.
- Zero register (ZERO_REG=1):
  - Writes to N-1 are ignored.
  - Allocs to N-1 are ignored.
  - Reads of N-1 return 0 and are never bypassed.
  - Pending[N-1] is constant 0.
- Read data, per port:
  - Address is the zero register: 0.
  - Otherwise, if BYPASS=1, reset=0 and write A matches the address: WriteData.
  - Otherwise, if the same conditions hold for write B: WriteDataB.
  - Otherwise: stored value.
- Scoreboard:
  - Alloc=1 sets pending[AllocReg] at the edge.
  - A write from either port clears pending for its address at the edge.
  - Alloc and a write to the same register in one cycle leave the bit set; the alloc belongs to a younger instruction.
- Pending outputs:
  - PendingN = pending[ReadRegisterN].
  - If BYPASS=1 and a write to that address is active this cycle, PendingN = 0 because the data is forwarded.
  - An alloc in the same cycle has no effect on PendingN until the next cycle.
- Both read ports are independent and may use the same address.

## Timing
- Read latency: 0 cycles, purely combinational from address, stored state and the current write inputs.
- Write visibility:
  - BYPASS=1: visible in the same cycle.
  - BYPASS=0: visible the cycle after the edge.
- Pending set by alloc is visible the cycle after the edge. Pending clear follows the same rule as write visibility.
- Reset:
  - Takes effect at the first rising edge with reset=1.
  - While reset=1, bypass is inhibited and outputs reflect stored state.
  - After that edge, ReadData1 = ReadData2 = 0 and Pending1 = Pending2 = 0 for every address.
- Reset asserted mid-operation discards in-flight writes and allocs in that cycle. No partial state survives.
- No handshake. Writes and allocs are unconditionally accepted every cycle.

## Test plan
- Reset then sweep: write reg i with 64'h1111_0000_0000_0000+i for i=0..30, then read all registers on both ports. Required: data back as written, and reg 31 reads 0 after writing 64'hFFFF_FFFF_FFFF_FFFF to it.
- Bypass: in one cycle set RegWrite=1, WriteRegister=5, WriteData=64'hDEAD, ReadRegister1=5. Required:
  - ReadData1=64'hDEAD in that same cycle, and stored value thereafter.
  - With BYPASS=0, the old value in that cycle and 64'hDEAD the next.
- Dual-write conflict: port A writes reg 7 with 64'hA and port B writes reg 7 with 64'hB in the same cycle, while ReadRegister2=7. Required: ReadData2=64'hA in the same cycle and 64'hA after the edge.
- Scoreboard:
  - Alloc reg 3: Pending1 (ReadRegister1=3) goes to 1 the next cycle and holds.
  - Port B then writes reg 3 with 64'h33: Pending1=0 and ReadData1=64'h33 in that cycle (bypass).
  - Alloc reg 3 and write reg 3 in the same cycle: pending remains 1.
- Reset mid-operation: with regs 0..30 nonzero and regs 2 and 9 pending, assert reset together with a write to reg 4 for one cycle. Required: all reads 0, Pending1=Pending2=0, and reg 4 reads 0, not the written value.
- Zero-register alloc: alloc reg 31, then read reg 31 on port 1. Required: Pending1=0 and ReadData1=0.
